hamming_secded_enc: RTL

HAMMING_SECDED_ENC -- requirements
Module: hamming_secded_enc

---
 rtl/hamming_secded_enc.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hamming_secded_enc.sv
// SECDED Hamming encoder with a one-deep ready/valid output register and a
// periodic error injector that flips one or two codeword bits on every INJ_PERIOD-th word.
module hamming_secded_enc #(
    parameter int DATA_W     = 4,
    parameter int INJ_PERIOD = 8,
    // Smallest r with 2^r >= DATA_W + r + 1, resolved for the legal width range 1..57
    localparam int PAR_W = (DATA_W <= 1)  ? 2 :
                           (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
    localparam int CW_W  = DATA_W + PAR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [1:0]        inj_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_code,
    output logic [1:0]        out_err
);

    localparam int POS_W = $clog2(CW_W);
    localparam int CNT_W = $clog2(INJ_PERIOD);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CW_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INJ_PERIOD - 1);

    function automatic bit is_pow2(input int p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Index of the data bit stored at Hamming position p (p must not be a power of two)
    function automatic int data_idx(input int p);
        int n;
        n = 0;
        for (int q = 3; q < p; q++) begin
            if (!is_pow2(q)) n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [CW_W-1:0] par_mask(input int p);
        logic [CW_W-1:0] m;
        m = '0;
        for (int q = 1; q < CW_W; q++) begin
            m[q] = ((q & p) != 0);
        end
        return m;
    endfunction

    logic [CW_W-1:0]  w_data_cw;
    logic [CW_W-1:0]  w_ham;
    logic [CW_W-1:0]  w_flip;
    logic [POS_W-1:0] w_pos_next;
    logic             w_accept;
    logic             w_inject;

    logic             r_valid;
    logic [CW_W-1:0]  r_code;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_wcnt;
    logic [POS_W-1:0] r_pos;

    assign w_data_cw[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < CW_W; gi++) begin : g_pos
            if (is_pow2(gi)) begin : g_par
                assign w_data_cw[gi] = 1'b0;
                assign w_ham[gi]     = ^(w_data_cw & par_mask(gi));
            end else begin : g_dat
                assign w_data_cw[gi] = in_data[data_idx(gi)];
                assign w_ham[gi]     = in_data[data_idx(gi)];
            end
        end
    endgenerate

    // Overall parity makes the full uninjected codeword XOR to zero
    assign w_ham[0] = ^w_ham[CW_W-1:1];

    assign in_ready   = !r_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_inject   = w_accept && (r_wcnt == CNT_LAST) && inj_en &&
                        ((inj_mode == 2'b01) || (inj_mode == 2'b10));
    assign w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;

    always_comb begin
        w_flip = '0;
        if (w_inject) begin
            w_flip = {{(CW_W-1){1'b0}}, 1'b1} << r_pos;
            if (inj_mode == 2'b10) begin
                w_flip = w_flip | ({{(CW_W-1){1'b0}}, 1'b1} << w_pos_next);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_err   <= 2'b00;
            r_wcnt  <= '0;
            r_pos   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_code  <= w_ham ^ w_flip;
                r_err   <= w_inject ? inj_mode : 2'b00;
                r_wcnt  <= (r_wcnt == CNT_LAST) ? '0 : r_wcnt + 1'b1;
                if (w_inject) r_pos <= w_pos_next;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_err   = r_err;

endmodule
